// File: rtl/reg_bank.sv
// 32 x DATA_W general-purpose register file: two combinational read ports,
// one synchronous write port, r0 hardwired to zero, r29 resets to SP_RESET.
module reg_bank #(
    parameter int unsigned SP_RESET = 227,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SP_IDX   = 29;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != 5'd0)) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    // Async reset also blocks any write on an edge that coincides with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: reads see the pre-edge contents.
    assign read_data1 = (read_reg1 == 5'd0) ? '0 : regs_q[read_reg1];
    assign read_data2 = (read_reg2 == 5'd0) ? '0 : regs_q[read_reg2];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected read data computed
// from an array model; a negedge monitor pops and compares.
module tb_reg_bank;

    localparam int unsigned SP = 227;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1, read_data2;

    reg_bank #(.SP_RESET(SP), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  a1;
        logic [4:0]  a2;
        string       nm;
    } exp_t;

    exp_t        exp_q[$];
    bit          chk_vld = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] mdl [32];
    bit          pend_we;
    logic [4:0]  pend_wa;
    logic [31:0] pend_wd;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl[29] = SP;
        pend_we = 1'b0;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    // One cycle: commit the previous cycle's write to the model at the edge,
    // then drive new inputs and queue what the read ports must show now.
    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input bit rst_n, input string nm);
        exp_t e;
        @(posedge clk);
        if (pend_we && reset && pend_wa != 5'd0) mdl[pend_wa] = pend_wd;
        pend_we = 1'b0;
        #1;
        chk_vld    = 1'b0;
        reset      = rst_n;
        if (!rst_n) model_reset();
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        e.e1 = model_rd(r1);
        e.e2 = model_rd(r2);
        e.a1 = r1;
        e.a2 = r2;
        e.nm = nm;
        exp_q.push_back(e);
        chk_vld = 1'b1;
        pend_we = we;
        pend_wa = wa;
        pend_wd = wd;
    endtask

    // Reset falls exactly on the edge that would commit the pending write.
    task automatic edge_reset();
        @(posedge clk);
        reset = 1'b0;
        model_reset();
        chk_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL monitor: output presented with empty scoreboard");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (read_data1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s port1 r%0d: got %h want %h", e.nm, e.a1, read_data1, e.e1);
                end
                n_cmp++;
                if (read_data2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s port2 r%0d: got %h want %h", e.nm, e.a2, read_data2, e.e2);
                end
            end
        end
    end

    initial begin
        int waited;
        reset      = 1'b0;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        model_reset();

        cyc(0, 5'd0,  32'h0,        5'd29, 5'd0,  0, "rst_r29_r0");
        cyc(1, 5'd7,  32'hAAAA5555, 5'd1,  5'd31, 0, "rst_blocks_wr");
        cyc(1, 5'd8,  32'hDEADBEEF, 5'd7,  5'd0,  1, "release");
        cyc(1, 5'd0,  32'hFFFFFFFF, 5'd8,  5'd9,  1, "wr_r8");
        cyc(0, 5'd5,  32'h12345678, 5'd0,  5'd0,  1, "r0_prot");
        cyc(0, 5'd5,  32'h12345678, 5'd5,  5'd5,  1, "we_gate1");
        cyc(0, 5'd5,  32'h12345678, 5'd5,  5'd5,  1, "we_gate2");
        cyc(1, 5'd31, 32'h10,       5'd5,  5'd0,  1, "we_gate3");
        cyc(1, 5'd31, 32'h20,       5'd31, 5'd31, 1, "nofwd_before");
        cyc(1, 5'd29, 32'h55,       5'd31, 5'd31, 1, "nofwd_after");
        cyc(1, 5'd3,  32'h77,       5'd29, 5'd3,  1, "sp_written");
        edge_reset();
        cyc(0, 5'd0,  32'h0,        5'd29, 5'd3,  0, "edge_rst");
        cyc(1, 5'd3,  32'h99,       5'd3,  5'd29, 1, "post_rel_wr");
        cyc(0, 5'd0,  32'h0,        5'd3,  5'd3,  1, "post_rel_rd");

        for (int i = 0; i < 300; i++) begin
            bit rn;
            rn = ($urandom_range(0, 39) != 0);
            cyc(bit'($urandom_range(0, 1)), 5'($urandom), $urandom,
                5'($urandom), 5'($urandom), rn, "rand");
        end

        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
